read_sched: RTL and testbench
=============================

# read_sched

Round-robin scheduler that shares one wait-stated read channel between `N_REQ` requesters. It arbitrates requests and runs the READ/DLY/DONE handshake against the slave's `ws` (wait-state) input. It aborts reads that stall too long. All outputs are registered, so `rd`, `ds`, `gnt` and `err` are glitch-free. It sits between requesting agents and the shared read strobe/done-strobe pair of the memory-side interface.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–16.
- `WAIT_MAX`, default 8: number of ws-high DLY cycles tolerated before a read aborts; must be ≥ 1.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  request level per requester; sampled only in IDLE.
- `ws`  in  1  slave wait-state; sampled in DLY only.
- `gnt`  out  N_REQ  one-hot grant; held for the whole transaction, including DONE/ABORT.
- `rd`  out  1  read strobe to slave.
- `ds`  out  1  done strobe; 1-cycle pulse on successful completion.
- `err`  out  1  1-cycle pulse on timeout abort.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: all outputs 0.
  - READ: `rd`=1.
  - DLY: `rd`=1.
  - DONE: `ds`=1.
  - ABORT: `err`=1.
  - `gnt` is nonzero and `busy`=1 in READ, DLY, DONE and ABORT.
- Outputs are registered. Each output is decoded from the next state and loaded on the same edge as the state register. Outputs must not be driven combinationally from `glitch_ps`-style present state.
- IDLE with `req` ≠ 0:
  - Select the first set bit at or above `ptr`, scanning upward with wrap.
  - Load the one-hot `gnt`, clear `retry_cnt`, go to READ.
- IDLE with `req` = 0: stay in IDLE.
- READ → DLY unconditionally.
- DLY, `ws`=0 → DONE.
- DLY, `ws`=1, `retry_cnt` == WAIT_MAX−1 → ABORT.
- DLY, `ws`=1, otherwise: increment `retry_cnt`, go to READ.
- DONE → IDLE. ABORT → IDLE.
- On either DONE→IDLE or ABORT→IDLE: `ptr` ← (granted index + 1) mod N_REQ, and `gnt` clears.
- `retry_cnt` width is clog2(WAIT_MAX+1) bits. It never wraps; ABORT is entered before overflow.
- `req` changes during a transaction are ignored. A dropped request still completes or aborts normally.
- At least one IDLE cycle separates transactions, so a grant never changes without passing through `gnt`=0.
- Reset (any time, including mid-transaction):
  - State = IDLE, `ptr` = 0, `retry_cnt` = 0.
  - `gnt` = 0, `rd` = 0, `ds` = 0, `err` = 0, `busy` = 0, immediately and asynchronously.
  - First grant evaluation happens on the first rising edge after `reset_n` rises.
- All case statements have full coverage with defaults. Unused state encodings return to IDLE.

## Timing
- Best-case latency, with `req` seen in IDLE at edge 0:
  - `gnt`, `rd` and `busy` high from cycle 1.
  - DLY in cycle 2, `ds` pulse in cycle 3, IDLE in cycle 4.
  - Next grant no earlier than cycle 5.
- `rd` is continuous from READ entry through the last DLY. It never toggles between retries.
- `rd` falls on the same edge that `ds` or `err` rises.
- Each ws-high DLY cycle adds 2 cycles (READ + DLY).
- Successful read with k wait cycles (k < WAIT_MAX): `ds` at cycle 3 + 2k.
- Abort: `err` at cycle 1 + 2·WAIT_MAX.
- `ds` and `err` are mutually exclusive and never both high.

## Test plan
- Single read: `req`=0001 at cycle 0, `ws`=0 → `gnt`=0001 cycles 1–3, `rd` cycles 1–2, `ds` cycle 3, `busy` low cycle 4.
- Wait states: `ws`=1 in the first two DLY cycles → `rd` high cycles 1–6 without a gap, `ds` at cycle 7, `err` stays 0.
- Timeout: WAIT_MAX=3, `ws` stuck 1 → `rd` cycles 1–6, `err` cycle 7 only, `ds` never pulses, `ptr` advances.
- Round-robin: `req`=1111 held, `ws`=0 → grants 0001, 0010, 0100, 1000, 0001 at cycles 1, 5, 9, 13, 17. Also check that `req`=1010 starting from `ptr`=2 grants 1000 then 0010.
- Request drop: `req` deasserted during DLY → transaction still completes with `ds`, and the next grant goes to another pending requester.
- Reset mid-DLY: `reset_n` low asynchronously → all outputs 0 immediately. After release with `req`=0100, the first grant is 0100 and `ptr` restarts from 0.

Source files
------------

// File: rtl/read_sched.sv
// read_sched: round-robin arbiter in front of one wait-stated read channel.
// A granted requester gets a READ/DLY loop that repeats while the slave holds
// ws high; the read completes with a one-cycle ds pulse, or aborts with a
// one-cycle err pulse once WAIT_MAX ws-high DLY cycles have been seen.
//
// Handshake: rd is high from READ entry through the last DLY cycle without a
// gap. The slave answers through ws, which is looked at only in DLY: ws=0 there
// ends the read (ds next cycle), ws=1 asks for another READ+DLY round. rd falls
// on the same edge that ds or err rises. gnt is one-hot and held for the whole
// transaction, and it returns to zero for at least one IDLE cycle between
// transactions.
//
// Every output is a flop loaded from the next-state decode, so nothing the
// slave or the requesters see is built from combinational present-state logic.
module read_sched #(
    parameter int N_REQ    = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ws,
    output logic [N_REQ-1:0] gnt,
    output logic             rd,
    output logic             ds,
    output logic             err,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DLY   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rd_q, rd_d;
    logic             ds_q, ds_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    int               scan_idx;

    // Round-robin pick: first requesting index at or above ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(ptr_q) + i) % N_REQ;
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state logic, plus the output values decoded from the next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        retry_cnt_d = retry_cnt_q;
        gnt_d       = gnt_q;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d     = S_READ;
                    gidx_d      = sel_idx;
                    retry_cnt_d = '0;
                    gnt_d       = N_REQ'(1) << sel_idx;
                end
            end
            S_READ: begin
                state_d = S_DLY;
            end
            S_DLY: begin
                if (!ws) begin
                    state_d = S_DONE;
                end else if (retry_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    // Abort before the counter could ever pass WAIT_MAX.
                    state_d = S_ABORT;
                end else begin
                    retry_cnt_d = retry_cnt_q + CNT_W'(1);
                    state_d     = S_READ;
                end
            end
            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
            end
            default: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                retry_cnt_d = '0;
            end
        endcase

        rd_d   = (state_d == S_READ) || (state_d == S_DLY);
        ds_d   = (state_d == S_DONE);
        err_d  = (state_d == S_ABORT);
        busy_d = (state_d != S_IDLE);
    end

    // State, arbitration pointer, retry counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            retry_cnt_q <= '0;
            gnt_q       <= '0;
            rd_q        <= 1'b0;
            ds_q        <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            retry_cnt_q <= retry_cnt_d;
            gnt_q       <= gnt_d;
            rd_q        <= rd_d;
            ds_q        <= ds_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rd        = rd_q;
    assign ds        = ds_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_read_sched.sv
// tb_read_sched: directed and random transactions against read_sched.
// The driver predicts each transaction (grant, outcome, start/end cycle, rd
// run length) from the arbitration and timing rules and queues it; the
// monitor rebuilds the same record from the pins and compares on ds/err.
module tb_read_sched;

    localparam int N     = 4;
    localparam int W     = 3;
    localparam int REC_W = N + 1 + 1 + 16 + 16 + 8 + 1;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] req     = '0;
    logic         ws      = 1'b0;
    logic [N-1:0] gnt;
    logic         rd, ds, err, busy;
    logic [2:0]   dbg_state;

    read_sched #(.N_REQ(N), .WAIT_MAX(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .ws        (ws),
        .gnt       (gnt),
        .rd        (rd),
        .ds        (ds),
        .err       (err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [REC_W-1:0] exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;

    function automatic logic [REC_W-1:0] pack(input logic [N-1:0] g, input logic e,
                                              input logic b, input int s, input int f,
                                              input int rdn, input logic gap);
        return {g, e, b, 16'(s), 16'(f), 8'(rdn), gap};
    endfunction

    // Reference arbitration: first requester at or after the pointer, with wrap.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Drive one transaction: r is sampled in IDLE, r_mid is applied while busy,
    // k ws-high DLY cycles (k >= W means the read times out).
    task automatic run_txn(input logic [N-1:0] r, input int k, input logic [N-1:0] r_mid);
        int           g;
        int           len;
        int           issue;
        logic [N-1:0] gv;
        req = r;
        ws  = 1'($urandom_range(0, 1));
        if (r == '0) begin
            @(posedge clk); #1;
            return;
        end
        g      = pick(r, model_ptr);
        gv     = '0;
        gv[g]  = 1'b1;
        len    = (k >= W) ? (1 + 2 * W) : (3 + 2 * k);
        issue  = cyc + 1;
        exp_q.push_back(pack(gv, k >= W, 1'b1, issue, issue + len - 1, len - 1, 1'b0));
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            req = r_mid;
            if (c % 2 == 0) ws = ((c - 2) / 2 < k);
            else            ws = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        model_ptr = (g + 1) % N;
    endtask

    // monitor
    logic         act      = 1'b0;
    logic         post     = 1'b0;
    logic         gap      = 1'b0;
    logic         seen_low = 1'b0;
    logic [N-1:0] act_gnt  = '0;
    logic [N-1:0] prev_gnt = '0;
    int           act_start = 0;
    int           rd_run    = 0;
    logic [REC_W-1:0] got, want;

    always @(negedge clk) begin
        if (!reset_n) begin
            act      = 1'b0;
            post     = 1'b0;
            prev_gnt = '0;
        end else begin
            checks++;
            if (ds && err) begin
                errors++;
                $display("FAIL ds_err_excl cyc=%0d ds=%b err=%b want not both", cyc, ds, err);
            end
            checks++;
            if (busy !== (gnt != '0)) begin
                errors++;
                $display("FAIL busy_gnt cyc=%0d busy=%b gnt=%b want busy==(gnt!=0)", cyc, busy, gnt);
            end
            if (post) begin
                checks++;
                if (gnt !== '0 || busy !== 1'b0 || rd !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gap cyc=%0d gnt=%b busy=%b rd=%b want all 0", cyc, gnt, busy, rd);
                end
                post = 1'b0;
            end
            if (!act && gnt != '0 && prev_gnt == '0) begin
                act       = 1'b1;
                act_gnt   = gnt;
                act_start = cyc;
                rd_run    = 0;
                gap       = 1'b0;
                seen_low  = 1'b0;
            end
            if (act) begin
                if (rd) begin
                    if (seen_low) gap = 1'b1;
                    else          rd_run++;
                end else begin
                    seen_low = 1'b1;
                end
                if (ds || err) begin
                    checks++;
                    got = pack(gnt, err, busy, act_start, cyc, rd_run, gap);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txn_unexpected cyc=%0d got=%h want none", cyc, got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL txn cyc=%0d got=%h want=%h (gnt,err,busy,start,end,rd_run,gap)",
                                     cyc, got, want);
                        end
                    end
                    act  = 1'b0;
                    post = 1'b1;
                end
            end
            prev_gnt = gnt;
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        logic [N-1:0] r, m;
        int           k;

        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rd, ds, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_out gnt=%b rd=%b ds=%b err=%b busy=%b want all 0", gnt, rd, ds, err, busy);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // round-robin with all requesting
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 4'b1111);
        run_txn(4'b0000, 0, 4'b0000);
        // single read, then wait states
        run_txn(4'b0001, 0, 4'b0001);
        run_txn(4'b0010, 2, 4'b0010);
        // 1010 from pointer 2
        run_txn(4'b1010, 0, 4'b1010);
        run_txn(4'b1010, 0, 4'b1010);
        // timeout, then show the pointer moved past the aborted requester
        run_txn(4'b0100, W, 4'b0100);
        run_txn(4'b0101, 0, 4'b0101);
        // request dropped mid-transaction, other requester served next
        run_txn(4'b0011, 1, 4'b0001);
        run_txn(4'b0001, 0, 4'b0001);
        run_txn(4'b0010, 0, 4'b0010);

        // asynchronous reset in the middle of DLY
        req = 4'b0100;
        ws  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rd, ds, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid gnt=%b rd=%b ds=%b err=%b busy=%b want all 0", gnt, rd, ds, err, busy);
        end
        model_ptr = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_txn(4'b1010, 0, 4'b1010);
        run_txn(4'b0100, 1, 4'b0100);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            k = $urandom_range(0, W);
            m = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : r;
            run_txn(r, k, m);
        end

        req = '0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_txns left=%0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
